// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, radix constants and a digit-range check.
package bcd_pkg;

    localparam int BCD_W     = 4;
    localparam int BCD_RADIX = 10;
    localparam int BCD_MAX   = 9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= bcd_digit_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_sub_digit_core.sv
// Combinational single-digit BCD subtract: a - b - borrowIn with decimal borrow.
module bcd_sub_digit_core
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       borrowIn,
    output bcd_digit_t result,
    output logic       borrowOut,
    output logic       digitErr
);

    logic [BCD_W:0] diff;
    logic           bad;

    assign bad  = !is_bcd(a) || !is_bcd(b);
    assign diff = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, borrowIn};

    // Bit BCD_W is the binary borrow; adding the radix mod 16 folds -10..-1 back to 0..9.
    always_comb begin
        result    = '0;
        borrowOut = 1'b0;
        digitErr  = 1'b0;
        if (bad) begin
            digitErr = 1'b1;
        end else if (diff[BCD_W]) begin
            result    = diff[BCD_W-1:0] + bcd_digit_t'(BCD_RADIX);
            borrowOut = 1'b1;
        end else begin
            result = diff[BCD_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_sub_digit.sv
// Registered single-digit BCD subtractor: one-cycle latency, one op per cycle.
module bcd_sub_digit
    import bcd_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               borrowIn,
    output logic               outValid,
    output logic [DIGIT_W-1:0] result,
    output logic               borrowOut,
    output logic               digitErr
);

    bcd_digit_t core_result;
    logic       core_borrow;
    logic       core_err;

    bcd_sub_digit_core u_core (
        .a        (bcd_digit_t'(a)),
        .b        (bcd_digit_t'(b)),
        .borrowIn (borrowIn),
        .result   (core_result),
        .borrowOut(core_borrow),
        .digitErr (core_err)
    );

    // Data outputs hold across idle cycles; only outValid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid  <= 1'b0;
            result    <= '0;
            borrowOut <= 1'b0;
            digitErr  <= 1'b0;
        end else begin
            outValid <= inValid;
            if (inValid) begin
                result    <= DIGIT_W'(core_result);
                borrowOut <= core_borrow;
                digitErr  <= core_err;
            end
        end
    end

endmodule

// File: tb/tb_bcd_sub_digit.sv
// Self-checking bench for bcd_sub_digit: directed table, exhaustive sweep, random ops, reset/hold.
module tb_bcd_sub_digit;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic [3:0] a, b;
    logic       borrowIn;
    logic       outValid;
    logic [3:0] result;
    logic       borrowOut;
    logic       digitErr;

    int checks = 0;
    int errors = 0;

    bcd_sub_digit #(.DIGIT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .a        (a),
        .b        (b),
        .borrowIn (borrowIn),
        .outValid (outValid),
        .result   (result),
        .borrowOut(borrowOut),
        .digitErr (digitErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] r;
        logic       bo;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    // Decimal reference: plain integer arithmetic on the digit values.
    function automatic logic [5:0] ref_sub(input int ra, input int rb, input int rbin);
        int d;
        if (ra > 9 || rb > 9) return {4'd0, 1'b0, 1'b1};
        d = ra - rb - rbin;
        if (d < 0) return {4'(d + 10), 1'b1, 1'b0};
        return {4'(d), 1'b0, 1'b0};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {outValid, result, borrowOut, digitErr};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b r=%0d bo=%0b err=%0b, want v=%0b r=%0d bo=%0b err=%0b",
                     name, act[6], act[5:2], act[1], act[0], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] da, input logic [3:0] db, input logic dbin);
        inValid  = v;
        a        = da;
        b        = db;
        borrowIn = dbin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] held;
    logic [5:0] e;

    initial begin
        vecs[0]  = '{4'd5,  4'd2,  1'b0, 4'd3, 1'b0, 1'b0};
        vecs[1]  = '{4'd8,  4'd8,  1'b0, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{4'd9,  4'd0,  1'b0, 4'd9, 1'b0, 1'b0};
        vecs[3]  = '{4'd3,  4'd7,  1'b0, 4'd6, 1'b1, 1'b0};
        vecs[4]  = '{4'd0,  4'd9,  1'b0, 4'd1, 1'b1, 1'b0};
        vecs[5]  = '{4'd2,  4'd5,  1'b1, 4'd6, 1'b1, 1'b0};
        vecs[6]  = '{4'd5,  4'd2,  1'b1, 4'd2, 1'b0, 1'b0};
        vecs[7]  = '{4'd0,  4'd0,  1'b1, 4'd9, 1'b1, 1'b0};
        vecs[8]  = '{4'd9,  4'd9,  1'b1, 4'd9, 1'b1, 1'b0};
        vecs[9]  = '{4'd12, 4'd3,  1'b0, 4'd0, 1'b0, 1'b1};
        vecs[10] = '{4'd4,  4'd15, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[11] = '{4'd5,  4'd2,  1'b0, 4'd3, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        check("reset_state", 7'b0);

        // Reset wins over a simultaneous valid op.
        drive(1'b1, 4'd3, 4'd7, 1'b0);
        tick();
        check("reset_priority", 7'b0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();

        // Directed table, back-to-back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
            tick();
            check($sformatf("vec%0d", i), {1'b1, vecs[i].r, vecs[i].bo, vecs[i].err});
        end

        // Exhaustive valid sweep, one op per cycle.
        for (int ia = 0; ia < 10; ia++)
            for (int ib = 0; ib < 10; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    drive(1'b1, 4'(ia), 4'(ib), 1'(ic));
                    tick();
                    check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ic), {1'b1, ref_sub(ia, ib, ic)});
                end

        // Hold: one op, then idle with garbage inputs.
        drive(1'b1, 4'd3, 4'd7, 1'b0);
        tick();
        check("hold_op", {1'b1, 4'd6, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
            check($sformatf("hold_idle%0d", k), {1'b0, 4'd6, 1'b1, 1'b0});
        end

        // Random traffic with gaps and non-BCD codes; model tracks held outputs.
        held = {4'd6, 1'b1, 1'b0};
        for (int k = 0; k < 400; k++) begin
            logic       v;
            logic [3:0] ra, rb;
            logic       rc;
            v  = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rc = 1'($urandom_range(0, 1));
            drive(v, ra, rb, rc);
            tick();
            if (v) held = ref_sub(int'(ra), int'(rb), int'(rc));
            e = held;
            check($sformatf("rand%0d", k), {v, e});
        end

        // Mid-stream reset clears everything.
        drive(1'b1, 4'd9, 4'd0, 1'b0);
        rst = 1'b1;
        tick();
        check("reset_midstream", 7'b0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        check("after_reset_idle", 7'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
